me_host_ctrl: RTL and testbench

ME_HOST_CTRL -- requirements
Module: me_host_ctrl

---
 rtl/me_host_ctrl.sv | 131 +++++++++++++
 tb/tb_me_host_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_host_ctrl.sv
// Host-side controller for the motion-estimation core: streams template and
// search-window pixels into their memories, runs one search, then holds the result.
module me_host_ctrl #(
  parameter  int TB_LENGTH    = 16,
  parameter  int SW_LENGTH    = 64,
  parameter  int PE_OUT_WIDTH = 8,
  localparam int ADDR_SW      = $clog2(SW_LENGTH * SW_LENGTH),
  localparam int ADDR_TB      = $clog2(TB_LENGTH * TB_LENGTH),
  localparam int CNT_WIDTH    = $clog2((SW_LENGTH - TB_LENGTH + 1) * (SW_LENGTH - TB_LENGTH + 1)),
  localparam int SAD_WIDTH    = $clog2(TB_LENGTH * TB_LENGTH) + PE_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pix_valid,
  input  logic [7:0]           pix_data,
  output logic                 pix_ready,
  output logic                 mem_wren_tb,
  output logic                 mem_wren_sw,
  output logic [ADDR_TB-1:0]   mem_addr_tb,
  output logic [ADDR_SW-1:0]   mem_addr_sw,
  output logic [7:0]           mem_data,
  input  logic [ADDR_TB-1:0]   me_addr_tb,
  input  logic [ADDR_SW-1:0]   me_addr_sw,
  output logic                 me_req,
  input  logic                 me_ack,
  input  logic [SAD_WIDTH-1:0] me_min_sad,
  input  logic [CNT_WIDTH-1:0] me_min_mvec,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SAD_WIDTH-1:0] res_sad,
  output logic [CNT_WIDTH-1:0] res_mvec,
  output logic [31:0]          res_cycles,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_TB,
    S_LOAD_SW,
    S_SEARCH,
    S_DRAIN,
    S_RESULT
  } state_t;

  // The load counter spans the larger window image; the template uses its low bits.
  localparam logic [ADDR_SW-1:0] LAST_TB = ADDR_SW'(TB_LENGTH * TB_LENGTH - 1);
  localparam logic [ADDR_SW-1:0] LAST_SW = ADDR_SW'(SW_LENGTH * SW_LENGTH - 1);

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_SW-1:0]   r_load_cnt;
  logic [31:0]          r_search_cnt;
  logic [31:0]          w_search_inc;
  logic                 r_me_req;
  logic [SAD_WIDTH-1:0] r_res_sad;
  logic [CNT_WIDTH-1:0] r_res_mvec;
  logic [31:0]          r_res_cycles;
  logic                 w_in_tb;
  logic                 w_in_sw;
  logic                 w_xfer;
  logic                 w_last;

  assign w_in_tb      = (r_state == S_LOAD_TB);
  assign w_in_sw      = (r_state == S_LOAD_SW);
  assign w_xfer       = (w_in_tb || w_in_sw) && pix_valid;
  assign w_last       = (w_in_tb && (r_load_cnt == LAST_TB)) ||
                        (w_in_sw && (r_load_cnt == LAST_SW));
  assign w_search_inc = (r_search_cnt == '1) ? r_search_cnt : r_search_cnt + 32'd1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start)            w_next = S_LOAD_TB;
      S_LOAD_TB: if (w_xfer && w_last) w_next = S_LOAD_SW;
      S_LOAD_SW: if (w_xfer && w_last) w_next = S_SEARCH;
      S_SEARCH:  if (me_ack)           w_next = S_DRAIN;
      S_DRAIN:   if (!me_ack)          w_next = S_RESULT;
      S_RESULT:  if (res_ready)        w_next = S_IDLE;
      default:                         w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_load_cnt   <= '0;
      r_search_cnt <= '0;
      r_me_req     <= 1'b0;
      r_res_sad    <= '0;
      r_res_mvec   <= '0;
      r_res_cycles <= '0;
    end else begin
      r_state  <= w_next;
      r_me_req <= (w_next == S_SEARCH);

      if (r_state == S_IDLE) begin
        r_load_cnt <= '0;
      end else if (w_xfer) begin
        r_load_cnt <= w_last ? '0 : r_load_cnt + ADDR_SW'(1);
      end

      // Latency counter lives outside the result registers so they hold while searching.
      if (r_state != S_SEARCH) begin
        r_search_cnt <= '0;
      end else begin
        r_search_cnt <= w_search_inc;
      end

      if ((r_state == S_SEARCH) && me_ack) begin
        r_res_sad    <= me_min_sad;
        r_res_mvec   <= me_min_mvec;
        r_res_cycles <= w_search_inc;
      end
    end
  end

  assign pix_ready   = w_in_tb || w_in_sw;
  assign mem_wren_tb = w_in_tb && pix_valid;
  assign mem_wren_sw = w_in_sw && pix_valid;
  assign mem_addr_tb = w_in_tb ? r_load_cnt[ADDR_TB-1:0] : me_addr_tb;
  assign mem_addr_sw = w_in_sw ? r_load_cnt : me_addr_sw;
  assign mem_data    = pix_data;
  assign me_req      = r_me_req;
  assign res_valid   = (r_state == S_RESULT);
  assign busy        = (r_state != S_IDLE);
  assign res_sad     = r_res_sad;
  assign res_mvec    = r_res_mvec;
  assign res_cycles  = r_res_cycles;

endmodule

// File: tb/tb_me_host_ctrl.sv
// Bench for me_host_ctrl: table and random jobs against a stub search core,
// with a memory-image model and mid-job reset scenarios.
module tb_me_host_ctrl;

  localparam int TB_LENGTH    = 16;
  localparam int SW_LENGTH    = 64;
  localparam int PE_OUT_WIDTH = 8;
  localparam int NTB          = TB_LENGTH * TB_LENGTH;
  localparam int NSW          = SW_LENGTH * SW_LENGTH;
  localparam int NPIX         = NTB + NSW;
  localparam int ADDR_SW      = $clog2(NSW);
  localparam int ADDR_TB      = $clog2(NTB);
  localparam int CNT_WIDTH    = $clog2((SW_LENGTH - TB_LENGTH + 1) * (SW_LENGTH - TB_LENGTH + 1));
  localparam int SAD_WIDTH    = $clog2(NTB) + PE_OUT_WIDTH;

  typedef struct {
    int                   gapPct;
    int                   startNoise;
    int                   delay;
    int                   hold;
    int                   readyWait;
    logic [SAD_WIDTH-1:0] sad;
    logic [CNT_WIDTH-1:0] mvec;
    logic [SAD_WIDTH-1:0] expSad;
    logic [CNT_WIDTH-1:0] expMvec;
    logic [31:0]          expCycles;
  } vecT;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 pix_valid;
  logic [7:0]           pix_data;
  logic                 pix_ready;
  logic                 mem_wren_tb;
  logic                 mem_wren_sw;
  logic [ADDR_TB-1:0]   mem_addr_tb;
  logic [ADDR_SW-1:0]   mem_addr_sw;
  logic [7:0]           mem_data;
  logic [ADDR_TB-1:0]   me_addr_tb;
  logic [ADDR_SW-1:0]   me_addr_sw;
  logic                 me_req;
  logic                 me_ack;
  logic [SAD_WIDTH-1:0] me_min_sad;
  logic [CNT_WIDTH-1:0] me_min_mvec;
  logic                 res_valid;
  logic                 res_ready;
  logic [SAD_WIDTH-1:0] res_sad;
  logic [CNT_WIDTH-1:0] res_mvec;
  logic [31:0]          res_cycles;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] px    [NPIX];
  logic [7:0] tbImg [NTB];
  logic [7:0] swImg [NSW];
  int         tbWr  [NTB];
  int         swWr  [NSW];
  int         strayWr;

  me_host_ctrl #(
    .TB_LENGTH   (TB_LENGTH),
    .SW_LENGTH   (SW_LENGTH),
    .PE_OUT_WIDTH(PE_OUT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .mem_wren_tb(mem_wren_tb),
    .mem_wren_sw(mem_wren_sw),
    .mem_addr_tb(mem_addr_tb),
    .mem_addr_sw(mem_addr_sw),
    .mem_data   (mem_data),
    .me_addr_tb (me_addr_tb),
    .me_addr_sw (me_addr_sw),
    .me_req     (me_req),
    .me_ack     (me_ack),
    .me_min_sad (me_min_sad),
    .me_min_mvec(me_min_mvec),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sad    (res_sad),
    .res_mvec   (res_mvec),
    .res_cycles (res_cycles),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memories modelled as plain arrays, written from the strobes seen mid-cycle.
  always @(negedge clk) begin
    if ((mem_wren_tb || mem_wren_sw) && !(pix_valid && pix_ready)) strayWr++;
    if (mem_wren_tb && mem_wren_sw) strayWr++;
    if (mem_wren_tb === 1'b1) begin
      tbImg[mem_addr_tb] = mem_data;
      tbWr[mem_addr_tb]++;
    end
    if (mem_wren_sw === 1'b1) begin
      swImg[mem_addr_sw] = mem_data;
      swWr[mem_addr_sw]++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearMonitor;
    for (int i = 0; i < NTB; i++) begin tbWr[i] = 0; tbImg[i] = 8'h00; end
    for (int i = 0; i < NSW; i++) begin swWr[i] = 0; swImg[i] = 8'h00; end
    strayWr = 0;
    for (int i = 0; i < NPIX; i++) px[i] = 8'($urandom);
  endtask

  task automatic startJob;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Streams pixels px[0..limit-1]; the model position is simply the count accepted so far.
  task automatic loadPixels(input int gapPct, input int noise, input int limit);
    int idx    = 0;
    int budget = 0;
    int errs   = 0;
    while (idx < limit && budget < 40000) begin
      pix_valid  = ($urandom_range(99) >= gapPct);
      pix_data   = px[idx];
      start      = (noise != 0) && ($urandom_range(19) == 0);
      me_addr_tb = ADDR_TB'($urandom);
      me_addr_sw = ADDR_SW'($urandom);
      @(negedge clk);
      if (pix_ready !== 1'b1 || busy !== 1'b1 || me_req !== 1'b0 || res_valid !== 1'b0) errs++;
      if (mem_wren_tb !== (pix_valid && idx < NTB)) errs++;
      if (mem_wren_sw !== (pix_valid && idx >= NTB)) errs++;
      if (idx < NTB) begin
        if (mem_addr_tb !== ADDR_TB'(idx) || mem_addr_sw !== me_addr_sw) errs++;
      end else begin
        if (mem_addr_sw !== ADDR_SW'(idx - NTB) || mem_addr_tb !== me_addr_tb) errs++;
      end
      if (mem_data !== pix_data) errs++;
      if (pix_valid) idx++;
      tick;
      budget++;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    checkOutput("load_cycle_behaviour", 64'(errs), 64'(0));
    checkOutput("load_pixels_accepted", 64'(idx), 64'(limit));
  endtask

  task automatic checkImages;
    int bad = 0;
    for (int i = 0; i < NTB; i++) if (tbImg[i] !== px[i] || tbWr[i] != 1) bad++;
    for (int i = 0; i < NSW; i++) if (swImg[i] !== px[NTB + i] || swWr[i] != 1) bad++;
    checkOutput("memory_image_write_once", 64'(bad), 64'(0));
    checkOutput("tb_last_addr_writes", 64'(tbWr[NTB-1]), 64'(1));
    checkOutput("sw_last_addr_writes", 64'(swWr[NSW-1]), 64'(1));
    checkOutput("stray_write_strobes", 64'(strayWr), 64'(0));
  endtask

  task automatic checkResetOutputs(input string name);
    @(negedge clk);
    checkOutput({name, "_ctrl"},
                64'({pix_ready, mem_wren_tb, mem_wren_sw, me_req, res_valid, busy}), 64'(0));
    checkOutput({name, "_results"}, 64'({res_sad, res_mvec, res_cycles}), 64'(0));
  endtask

  task automatic applyStimulus(input vecT v);
    int errs = 0;
    clearMonitor;
    startJob;
    loadPixels(v.gapPct, v.startNoise, NPIX);
    checkImages;

    // Stub search core: ack in the delay-th SEARCH cycle, result valid only on that cycle.
    for (int n = 1; n <= v.delay; n++) begin
      me_ack      = (n == v.delay);
      me_min_sad  = (n == v.delay) ? v.sad  : SAD_WIDTH'($urandom);
      me_min_mvec = (n == v.delay) ? v.mvec : CNT_WIDTH'($urandom);
      pix_valid   = 1'b1;
      start       = (v.startNoise != 0) && ($urandom_range(3) == 0);
      me_addr_tb  = ADDR_TB'($urandom);
      me_addr_sw  = ADDR_SW'($urandom);
      @(negedge clk);
      if (n == 1) checkOutput("first_search_ready_req", 64'({pix_ready, me_req}), 64'(2'b01));
      if (me_req !== 1'b1 || pix_ready !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0) errs++;
      if (mem_wren_tb !== 1'b0 || mem_wren_sw !== 1'b0) errs++;
      if (mem_addr_tb !== me_addr_tb || mem_addr_sw !== me_addr_sw) errs++;
      tick;
    end
    me_min_sad  = ~v.sad;
    me_min_mvec = ~v.mvec;
    pix_valid   = 1'b0;
    start       = 1'b0;
    checkOutput("search_behaviour", 64'(errs), 64'(0));

    errs = 0;
    for (int h = 0; h <= v.hold; h++) begin
      me_ack = (h < v.hold);
      start  = (v.startNoise != 0) && ($urandom_range(1) == 0);
      @(negedge clk);
      if (me_req !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b1 || pix_ready !== 1'b0) errs++;
      tick;
    end
    me_ack = 1'b0;
    start  = 1'b0;
    checkOutput("drain_behaviour", 64'(errs), 64'(0));

    errs = 0;
    for (int w = 0; w <= v.readyWait; w++) begin
      res_ready = (w == v.readyWait);
      start     = (w == v.readyWait) || ($urandom_range(1) == 0);
      @(negedge clk);
      if (w == 0) begin
        checkOutput("res_sad", 64'(res_sad), 64'(v.expSad));
        checkOutput("res_mvec", 64'(res_mvec), 64'(v.expMvec));
        checkOutput("res_cycles", 64'(res_cycles), 64'(v.expCycles));
      end
      if (res_valid !== 1'b1 || busy !== 1'b1 || pix_ready !== 1'b0 || me_req !== 1'b0) errs++;
      if (res_sad !== v.expSad || res_mvec !== v.expMvec || res_cycles !== v.expCycles) errs++;
      tick;
    end
    res_ready = 1'b0;
    start     = 1'b0;
    checkOutput("result_behaviour", 64'(errs), 64'(0));

    @(negedge clk);
    checkOutput("idle_after_handshake", 64'({busy, res_valid, pix_ready, me_req}), 64'(0));
    checkOutput("results_held", 64'({res_sad, res_mvec, res_cycles}),
                64'({v.expSad, v.expMvec, v.expCycles}));
    errs = 0;
    repeat (2) begin
      tick;
      @(negedge clk);
      if (busy !== 1'b0 || pix_ready !== 1'b0) errs++;
    end
    checkOutput("start_with_ready_dropped", 64'(errs), 64'(0));
    tick;
  endtask

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vecT vecs [3];
    vecT rv;

    rst_n       = 1'b0;
    start       = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = 8'h00;
    me_addr_tb  = '0;
    me_addr_sw  = '0;
    me_ack      = 1'b0;
    me_min_sad  = '0;
    me_min_mvec = '0;
    res_ready   = 1'b0;
    strayWr     = 0;

    repeat (3) tick;
    checkResetOutputs("power_on_reset");
    rst_n = 1'b1;
    tick;

    vecs[0] = '{0,  0, 100, 0,  0, 16'd37,     12'd1200, 16'd37,     12'd1200, 32'd100};
    vecs[1] = '{30, 1, 7,   10, 3, 16'hBEEF,   12'd2400, 16'hBEEF,   12'd2400, 32'd7};
    vecs[2] = '{50, 1, 1,   2,  1, 16'd0,      12'd0,    16'd0,      12'd0,    32'd1};
    for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);

    for (int i = 0; i < 2; i++) begin
      rv.gapPct     = int'($urandom_range(40));
      rv.startNoise = 1;
      rv.delay      = int'($urandom_range(200, 1));
      rv.hold       = int'($urandom_range(12));
      rv.readyWait  = int'($urandom_range(5));
      rv.sad        = SAD_WIDTH'($urandom);
      rv.mvec       = CNT_WIDTH'($urandom);
      rv.expSad     = rv.sad;
      rv.expMvec    = rv.mvec;
      rv.expCycles  = 32'(rv.delay);
      applyStimulus(rv);
    end

    // Reset in the middle of the window load, then a clean job.
    clearMonitor;
    startJob;
    loadPixels(20, 1, NTB + 1000);
    pix_valid = 1'b1;
    rst_n     = 1'b0;
    tick;
    checkResetOutputs("reset_mid_load_sw");
    rst_n     = 1'b1;
    pix_valid = 1'b0;
    tick;
    applyStimulus(vecs[0]);

    // Reset while the search is running, then a clean job.
    clearMonitor;
    startJob;
    loadPixels(0, 0, NPIX);
    repeat (5) tick;
    rst_n = 1'b0;
    tick;
    checkResetOutputs("reset_mid_search");
    rst_n = 1'b1;
    tick;
    applyStimulus(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
